// File: rtl/k053251_cfg_seq_if.sv
// Host-side and mixer-side signals of the k053251 configuration sequencer.
// K053251_CTRL_READBACK_EN adds the RADDR/RDATA shadow readback pair.
interface k053251_cfg_seq_if;
  logic        WR;
  logic [3:0]  WADDR;
  logic [5:0]  WDATA;
  logic        VBL;
  logic        FORCE;
  logic        nCS;
  logic [3:0]  ADDR;
  logic [5:0]  DIN;
  logic        BUSY;
  logic        DONE;
  logic [12:0] DIRTY;
`ifdef K053251_CTRL_READBACK_EN
  logic [3:0]  RADDR;
  logic [5:0]  RDATA;

  modport master (output WR, WADDR, WDATA, VBL, FORCE, RADDR,
                  input  nCS, ADDR, DIN, BUSY, DONE, DIRTY, RDATA);
  modport slave  (input  WR, WADDR, WDATA, VBL, FORCE, RADDR,
                  output nCS, ADDR, DIN, BUSY, DONE, DIRTY, RDATA);
`else
  modport master (output WR, WADDR, WDATA, VBL, FORCE,
                  input  nCS, ADDR, DIN, BUSY, DONE, DIRTY);
  modport slave  (input  WR, WADDR, WDATA, VBL, FORCE,
                  output nCS, ADDR, DIN, BUSY, DONE, DIRTY);
`endif
endinterface

// File: rtl/k053251_cfg_seq.sv
// Shadows the 13 k053251 control registers and replays dirty entries onto the
// mixer write port on VBL rise or FORCE. K053251_CTRL_READBACK_EN adds RDATA.
module k053251_cfg_seq #(
  parameter int STROBE_LEN = 2
) (
  input  logic             CLK,
  input  logic             RST,
  k053251_cfg_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic [5:0]  din_q, din_d;
  logic        ncs_q, ncs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        vbl_q, vbl_d;
  logic [12:0] dirty_q, dirty_d;
  logic [5:0]  shadow_q [13];
  logic [5:0]  shadow_d [13];

  logic        trig, go_setup, host_wr;
  logic [3:0]  nxt;
  logic [12:0] set_m, clr_m;

  function automatic logic [3:0] lowest(input logic [12:0] m);
    lowest = 4'd0;
    for (int i = 12; i >= 0; i--)
      if (m[i]) lowest = i[3:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    done_d   = 1'b0;
    vbl_d    = bus.VBL;
    shadow_d = shadow_q;
    go_setup = 1'b0;
    set_m    = '0;
    clr_m    = '0;
    trig     = bus.FORCE | (bus.VBL & ~vbl_q);
    host_wr  = bus.WR && (bus.WADDR <= 4'd12);
    nxt      = lowest(dirty_q);

    if (host_wr) begin
      set_m[bus.WADDR]    = 1'b1;
      shadow_d[bus.WADDR] = (bus.WADDR == 4'd12) ? {3'b000, bus.WDATA[2:0]} : bus.WDATA;
    end

    unique case (state_q)
      IDLE: if (trig) begin
        if (dirty_q != '0) go_setup = 1'b1;
        else               done_d   = 1'b1;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'd0;
      end
      STROBE: begin
        if (cnt_q == 4'(STROBE_LEN - 1)) state_d = HOLD;
        else                             cnt_d   = cnt_q + 4'd1;
      end
      HOLD: begin
        if (dirty_q != '0) go_setup = 1'b1;
        else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    // Capture and clear on the same edge, so a same-edge host write keeps its dirty bit.
    if (go_setup) begin
      state_d    = SETUP;
      addr_d     = nxt;
      din_d      = shadow_q[nxt];
      clr_m[nxt] = 1'b1;
    end

    dirty_d = (dirty_q & ~clr_m) | set_m;
    ncs_d   = (state_d != STROBE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 4'd0;
      din_q    <= 6'd0;
      ncs_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vbl_q    <= 1'b0;
      dirty_q  <= 13'h1FFF;
      shadow_q <= '{default: 6'd0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      ncs_q    <= ncs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vbl_q    <= vbl_d;
      dirty_q  <= dirty_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.nCS   = ncs_q;
  assign bus.ADDR  = addr_q;
  assign bus.DIN   = din_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.DIRTY = dirty_q;

`ifdef K053251_CTRL_READBACK_EN
  assign bus.RDATA = (bus.RADDR <= 4'd12) ? shadow_q[bus.RADDR] : 6'd0;
`endif
endmodule

// File: doc/k053251_cfg_seq.md
# k053251_cfg_seq

Configuration sequencer for the k053251 priority/colour mixer. It holds a 13-entry shadow copy of the mixer's control registers (priorities, palette banks, transparency modes, priority-source select) that the host CPU can write at any time. At vertical blank, or on demand, it walks the changed entries and replays them onto the mixer's nCS/ADDR/DIN write port, so the mixer's configuration never changes mid-line. It sits between the CPU bus decode and the k053251 register port.

## Interface
Parameters:
- STROBE_LEN, 2: cycles nCS is held low per register write (1..15).

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR  in  1  host write strobe, one cycle per write.
- WADDR  in  4  host register index 0..12; values 13..15 are ignored.
- WDATA  in  6  host data; index 12 stores WDATA[2:0], with upper bits stored as 0.
- VBL  in  1  vertical-blank level; a rising edge requests a flush.
- FORCE  in  1  single-cycle flush request, independent of VBL.
- nCS  out  1  mixer chip select; the mixer latches on the nCS rising edge.
- ADDR  out  4  mixer register address.
- DIN  out  6  mixer register data.
- BUSY  out  1  high while a walk is in progress.
- DONE  out  1  one-cycle pulse when a walk (including an empty walk) ends.
- DIRTY  out  13  per-entry pending mask.

## Operation
- Host write: when WR=1 and WADDR≤12, the next clock edge stores shadow[WADDR] and sets DIRTY[WADDR]. Writes are always accepted, with no back-pressure.
- Trigger: a VBL rising edge (VBL registered once, edge = VBL & ~VBL_q) or FORCE=1, while in IDLE.
  - Triggers arriving while BUSY are dropped. The walk already re-scans DIRTY, so entries written mid-walk are still sent.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: on a trigger with DIRTY≠0, go to SETUP with idx = lowest set DIRTY bit. On a trigger with DIRTY=0, pulse DONE next cycle and stay in IDLE.
  - SETUP (1 cycle): drive ADDR=idx and DIN=shadow[idx] (captured on entry); nCS=1; clear DIRTY[idx].
  - STROBE (STROBE_LEN cycles): nCS=0; ADDR and DIN held.
  - HOLD (1 cycle): nCS=1; ADDR and DIN held, so the mixer latches stable data. Then go to SETUP if DIRTY≠0 (lowest index first), else go to IDLE and pulse DONE.
- Simultaneous events:
  - A host write to idx on the same edge as SETUP clears it: the set wins, DIRTY[idx] stays 1, and the new value is resent later in the same walk.
  - A host write to idx during STROBE or HOLD sets DIRTY again and does not alter the in-flight ADDR/DIN.
- Reset values:
  - nCS=1, ADDR=0, DIN=0, BUSY=0, DONE=0.
  - Shadow all 0; DIRTY=13'h1FFF, so the first flush initialises every mixer register.
  - FSM=IDLE; VBL_q=0.
- Reset mid-walk: nCS returns high asynchronously, which may cause one spurious mixer latch. This is acceptable because DIRTY resets to all ones and the next flush overwrites every register.

## Timing
- Per register: STROBE_LEN+2 cycles. A full 13-entry walk at the default takes 52 cycles from the first SETUP.
- Trigger to first SETUP: 1 cycle after the trigger edge is detected. VBL adds one cycle of registration.
- BUSY is high from SETUP entry through the final HOLD and low in the cycle DONE pulses.
- DIRTY is visible one cycle after the WR edge.
- Output register timing:
  - ADDR and DIN are registered and change only on entry to SETUP.
  - nCS is registered.
  - No output glitches while ADDR/DIN are stable.

## Configuration
- K053251_CTRL_READBACK_EN:
  - Defined: adds ports RADDR (in 4) and RDATA (out 6). RDATA is the combinational shadow[RADDR]; RADDR 13..15 reads 0.
  - Undefined: these ports and their mux are absent; all other behaviour is identical.

## Test plan
- After RST, pulse FORCE → 13 writes at ADDR 0..12 with DIN=0, 4 cycles each; DONE pulses at cycle 53; DIRTY=0.
- WR addr 5 data 6'h2A and addr 12 data 6'h3F, then raise VBL → exactly two strobes: (5, 2A) then (12, 07); BUSY high 8 cycles.
- During the strobe of addr 3, write addr 3=6'h11 → the first strobe keeps the old value; a second strobe of (3, 11) follows in the same walk.
- FORCE with DIRTY=0 → DONE pulse next cycle, nCS stays 1, BUSY stays 0.
- Assert RST during STROBE → nCS=1 immediately, DIRTY=1FFF, FSM=IDLE; the next VBL edge rewrites all 13 registers.
- With READBACK_EN: write addr 9=6'h15, set RADDR=9 → RDATA=15 one cycle after the write; RADDR=14 → 0.
